// File: rtl/display_out_parallel_if.sv
// Pixel bus between the timing/colour source and the parallel RGB output stage.
// The master drives the i_* timing/colour inputs; the slave drives the o_* pin-side outputs.
interface display_out_parallel_if #(
  parameter int unsigned IN_BITS   = 8,
  parameter int unsigned COLR_BITS = 1
);
  logic                 i_hs;
  logic                 i_vs;
  logic                 i_de;
  logic                 i_frame;
  logic [15:0]          i_sx;
  logic [15:0]          i_sy;
  logic [IN_BITS-1:0]   i_red;
  logic [IN_BITS-1:0]   i_green;
  logic [IN_BITS-1:0]   i_blue;
  logic                 o_hs;
  logic                 o_vs;
  logic                 o_de;
  logic [COLR_BITS-1:0] o_red;
  logic [COLR_BITS-1:0] o_green;
  logic [COLR_BITS-1:0] o_blue;

  modport master (
    output i_hs, i_vs, i_de, i_frame, i_sx, i_sy, i_red, i_green, i_blue,
    input  o_hs, o_vs, o_de, o_red, o_green, o_blue
  );

  modport slave (
    input  i_hs, i_vs, i_de, i_frame, i_sx, i_sy, i_red, i_green, i_blue,
    output o_hs, o_vs, o_de, o_red, o_green, o_blue
  );
endinterface

// File: rtl/display_out_parallel.sv
// Parallel-RGB output stage: 2-cycle aligned timing/colour, DE blanking, colour reduction.
// DISPLAY_OUT_DITHER_EN builds the 4x4 Bayer ordered dither with a 4-phase frame rotation.
module display_out_parallel #(
  parameter int unsigned IN_BITS   = 8,
  parameter int unsigned COLR_BITS = 1,
  parameter bit          H_POL     = 1'b0,
  parameter bit          V_POL     = 1'b0
) (
  input  logic                   i_pix_clk,
  input  logic                   i_rst_n,
  display_out_parallel_if.slave  bus
);
  localparam int unsigned D   = IN_BITS - COLR_BITS;
  localparam int unsigned NCH = 3;

  logic [IN_BITS-1:0]            off_c;
  logic [NCH-1:0][IN_BITS-1:0]   pix_c;
  logic [NCH-1:0][IN_BITS-1:0]   sat_c;
  logic [NCH-1:0][IN_BITS:0]     sum_c;
  logic [NCH-1:0][COLR_BITS-1:0] s1_d, s1_q;
  logic [NCH-1:0][COLR_BITS-1:0] out_d, out_q;
  logic [1:0]                    hs_d, hs_q;
  logic [1:0]                    vs_d, vs_q;
  logic [1:0]                    de_d, de_q;
  logic                          unused_c;

  assign pix_c = {bus.i_blue, bus.i_green, bus.i_red};

`ifdef DISPLAY_OUT_DITHER_EN
  logic [1:0] fc_d, fc_q;
  logic [3:0] idx_c;
  logic [3:0] t_c;

  // Frame counter rotates the threshold matrix each frame.
  always_comb begin
    fc_d = fc_q;
    if (bus.i_frame) fc_d = fc_q + 2'd1;
  end

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) fc_q <= 2'd0;
    else          fc_q <= fc_d;
  end

  always_comb begin
    idx_c = {bus.i_sy[1:0], bus.i_sx[1:0]} ^ {fc_q, fc_q};
    t_c   = 4'd0;
    case (idx_c)
      4'd0:  t_c = 4'd0;   4'd1:  t_c = 4'd8;   4'd2:  t_c = 4'd2;   4'd3:  t_c = 4'd10;
      4'd4:  t_c = 4'd12;  4'd5:  t_c = 4'd4;   4'd6:  t_c = 4'd14;  4'd7:  t_c = 4'd6;
      4'd8:  t_c = 4'd3;   4'd9:  t_c = 4'd11;  4'd10: t_c = 4'd1;   4'd11: t_c = 4'd9;
      4'd12: t_c = 4'd15;  4'd13: t_c = 4'd7;   4'd14: t_c = 4'd13;  4'd15: t_c = 4'd5;
      default: t_c = 4'd0;
    endcase
  end

  // Scale the 4-bit threshold so it spans one output LSB.
  if (D == 0) begin : g_off_none
    assign off_c = '0;
  end else if (D >= 4) begin : g_off_shl
    assign off_c = IN_BITS'(t_c) << (D - 4);
  end else begin : g_off_shr
    assign off_c = IN_BITS'(t_c >> (4 - D));
  end

  assign unused_c = &{1'b0, bus.i_sx[15:2], bus.i_sy[15:2], t_c, sat_c, sum_c};
`else
  assign off_c    = '0;
  assign unused_c = &{1'b0, bus.i_sx, bus.i_sy, bus.i_frame, sat_c, sum_c};
`endif

  // Stage 1: saturating add of the offset, keep the top COLR_BITS.
  always_comb begin
    sum_c = '0;
    sat_c = '0;
    s1_d  = '0;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      sum_c[ch] = {1'b0, pix_c[ch]} + {1'b0, off_c};
      sat_c[ch] = sum_c[ch][IN_BITS] ? '1 : sum_c[ch][IN_BITS-1:0];
      s1_d[ch]  = sat_c[ch][IN_BITS-1 -: COLR_BITS];
    end
  end

  // Stage 2: blank colour with the stage-1 copy of de; timing shifts alongside.
  always_comb begin
    hs_d  = {hs_q[0], bus.i_hs};
    vs_d  = {vs_q[0], bus.i_vs};
    de_d  = {de_q[0], bus.i_de};
    out_d = '0;
    if (de_q[0]) out_d = s1_q;
  end

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hs_q  <= {2{~H_POL}};
      vs_q  <= {2{~V_POL}};
      de_q  <= 2'b00;
      s1_q  <= '0;
      out_q <= '0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      s1_q  <= s1_d;
      out_q <= out_d;
    end
  end

  assign bus.o_hs    = hs_q[1];
  assign bus.o_vs    = vs_q[1];
  assign bus.o_de    = de_q[1];
  assign bus.o_red   = out_q[0];
  assign bus.o_green = out_q[1];
  assign bus.o_blue  = out_q[2];
endmodule

// File: tb/tb_display_out_parallel.sv
// Scoreboard bench for display_out_parallel: a 1-bit active-low-sync instance and a
// 4-bit active-high-sync instance share stimulus; expectations come from a reference model.
module tb_display_out_parallel;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_out_parallel_if #(.IN_BITS(8), .COLR_BITS(1)) if1 ();
  display_out_parallel_if #(.IN_BITS(8), .COLR_BITS(4)) if4 ();

  display_out_parallel #(.IN_BITS(8), .COLR_BITS(1), .H_POL(1'b0), .V_POL(1'b0)) u1 (
    .i_pix_clk(clk), .i_rst_n(rst_n), .bus(if1.slave));
  display_out_parallel #(.IN_BITS(8), .COLR_BITS(4), .H_POL(1'b1), .V_POL(1'b1)) u4 (
    .i_pix_clk(clk), .i_rst_n(rst_n), .bus(if4.slave));

  typedef struct packed {
    logic hs, vs, de, frame;
    logic [15:0] sx, sy;
    logic [7:0] r, g, b;
  } in_t;

  typedef struct packed {
    logic [5:0]  e1;
    logic [14:0] e4;
    int          tag;
  } exp_t;

  localparam logic [5:0]  RST1 = 6'b110000;
  localparam logic [14:0] RST4 = 15'd0;

  exp_t       sb[$];
  int         n_chk;
  int         n_fail;
  logic [1:0] fcm;

`ifdef DISPLAY_OUT_DITHER_EN
  logic [3:0] bay [16] = '{4'd0, 4'd8, 4'd2, 4'd10, 4'd12, 4'd4, 4'd14, 4'd6,
                           4'd3, 4'd11, 4'd1, 4'd9, 4'd15, 4'd7, 4'd13, 4'd5};
`endif

  function automatic logic [3:0] quant(input logic [7:0] c, input logic [15:0] sx, sy,
                                       input logic [1:0] fc, input int cb, input logic de);
    int d, off, s;
    d   = 8 - cb;
    off = 0;
`ifdef DISPLAY_OUT_DITHER_EN
    begin
      logic [3:0] idx;
      idx = {sy[1:0], sx[1:0]} ^ {fc, fc};
      if (d >= 4)     off = int'(bay[idx]) << (d - 4);
      else if (d > 0) off = int'(bay[idx]) >> (4 - d);
    end
`else
    if (fc == 2'd3 && sx == sy) off = 0;
`endif
    s = int'(c) + off;
    if (s > 255) s = 255;
    if (!de) return 4'd0;
    return 4'(s >> d);
  endfunction

  function automatic in_t mk(input logic hs, vs, de, fr, input int sx, sy,
                             input logic [7:0] r, g, b);
    in_t x;
    x.hs = hs; x.vs = vs; x.de = de; x.frame = fr;
    x.sx = 16'(sx); x.sy = 16'(sy); x.r = r; x.g = g; x.b = b;
    return x;
  endfunction

  function automatic logic [5:0] act1();
    return {if1.o_hs, if1.o_vs, if1.o_de, if1.o_red, if1.o_green, if1.o_blue};
  endfunction

  function automatic logic [14:0] act4();
    return {if4.o_hs, if4.o_vs, if4.o_de, if4.o_red, if4.o_green, if4.o_blue};
  endfunction

  // Drive both instances and queue the model's expectation for two cycles later.
  task automatic apply(input in_t x, input int tag);
    exp_t e;
    logic [3:0] r1, g1, b1, r4, g4, b4;
    if1.i_hs = x.hs; if1.i_vs = x.vs; if1.i_de = x.de; if1.i_frame = x.frame;
    if1.i_sx = x.sx; if1.i_sy = x.sy; if1.i_red = x.r; if1.i_green = x.g; if1.i_blue = x.b;
    if4.i_hs = x.hs; if4.i_vs = x.vs; if4.i_de = x.de; if4.i_frame = x.frame;
    if4.i_sx = x.sx; if4.i_sy = x.sy; if4.i_red = x.r; if4.i_green = x.g; if4.i_blue = x.b;
    r1 = quant(x.r, x.sx, x.sy, fcm, 1, x.de);
    g1 = quant(x.g, x.sx, x.sy, fcm, 1, x.de);
    b1 = quant(x.b, x.sx, x.sy, fcm, 1, x.de);
    r4 = quant(x.r, x.sx, x.sy, fcm, 4, x.de);
    g4 = quant(x.g, x.sx, x.sy, fcm, 4, x.de);
    b4 = quant(x.b, x.sx, x.sy, fcm, 4, x.de);
    e.e1  = {x.hs, x.vs, x.de, r1[0], g1[0], b1[0]};
    e.e4  = {x.hs, x.vs, x.de, r4, g4, b4};
    e.tag = tag;
    sb.push_back(e);
    if (x.frame) fcm = fcm + 2'd1;
  endtask

  task automatic test_reset();
    in_t st[$];
    exp_t e;
    apply(mk(1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    n_chk++;
    if (act1() !== RST1) begin
      n_fail++; $display("FAIL reset_u1 got %b want %b", act1(), RST1);
    end
    n_chk++;
    if (act4() !== RST4) begin
      n_fail++; $display("FAIL reset_u4 got %b want %b", act4(), RST4);
    end
    for (int i = 0; i < 6; i++) st.push_back(mk(1, 1, 1, 0, i, 0, 8'hFF, 8'h00, 8'h80));
    rst_n = 1'b1;
    sb.push_back('{e1: RST1, e4: RST4, tag: 1});
    apply(st[0], 2);
    for (int i = 1; i < st.size(); i++) begin
      @(negedge clk);
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        n_chk++;
        if (act1() !== e.e1) begin n_fail++; $display("FAIL reset_rel tag %0d u1 got %b want %b", e.tag, act1(), e.e1); end
        n_chk++;
        if (act4() !== e.e4) begin n_fail++; $display("FAIL reset_rel tag %0d u4 got %b want %b", e.tag, act4(), e.e4); end
      end
      apply(st[i], 2);
    end
  endtask

  task automatic test_latency();
    in_t st[$];
    int tg[$];
    exp_t e;
    st.push_back(mk(1, 1, 1, 0, 0, 0, 8'h80, 8'h7F, 8'h00)); tg.push_back(10);
    st.push_back(mk(1, 1, 1, 0, 0, 0, 8'h7F, 8'h80, 8'hFF)); tg.push_back(11);
    for (int i = 0; i < 8; i++) begin
      st.push_back(mk(!(i >= 2 && i < 5), !(i == 6), 0, 0, 640 + i, 0, 8'hFF, 8'hFF, 8'hFF));
      tg.push_back(12);
    end
    st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0)); tg.push_back(0);
    st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0)); tg.push_back(0);
    foreach (st[i]) begin
      @(negedge clk);
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        n_chk++;
        if (act1() !== e.e1) begin n_fail++; $display("FAIL latency tag %0d u1 got %b want %b", e.tag, act1(), e.e1); end
        n_chk++;
        if (act4() !== e.e4) begin n_fail++; $display("FAIL latency tag %0d u4 got %b want %b", e.tag, act4(), e.e4); end
        if (e.tag == 10 || e.tag == 11) begin
          n_chk++;
          if ({if1.o_de, if1.o_red} !== {1'b1, (e.tag == 10)}) begin
            n_fail++; $display("FAIL latency_msb tag %0d got de/red %b%b want 1%b", e.tag, if1.o_de, if1.o_red, (e.tag == 10));
          end
        end
      end
      apply(st[i], tg[i]);
    end
  endtask

  task automatic test_blanking();
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        n_chk++;
        if (act1() !== e.e1) begin n_fail++; $display("FAIL blank tag %0d u1 got %b want %b", e.tag, act1(), e.e1); end
        n_chk++;
        if (act4() !== e.e4) begin n_fail++; $display("FAIL blank tag %0d u4 got %b want %b", e.tag, act4(), e.e4); end
        if (e.tag == 20) begin
          n_chk++;
          if ({if4.o_de, if4.o_red, if4.o_green, if4.o_blue} !== 13'd0) begin
            n_fail++; $display("FAIL blank_zero got %b want 0", {if4.o_de, if4.o_red, if4.o_green, if4.o_blue});
          end
        end
      end
      if (i < 8) apply(mk(i[0], 1, 0, 0, i - 4, i - 2, 8'hFF, 8'hFF, 8'hFF), 20);
      else       apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0), 0);
    end
  endtask

  task automatic test_patterns();
    exp_t e;
    in_t x;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        n_chk++;
        if (act1() !== e.e1) begin n_fail++; $display("FAIL pattern tag %0d u1 got %b want %b", e.tag, act1(), e.e1); end
        n_chk++;
        if (act4() !== e.e4) begin n_fail++; $display("FAIL pattern tag %0d u4 got %b want %b", e.tag, act4(), e.e4); end
      end
      x = mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 65535), $urandom_range(0, 65535),
             8'($urandom), 8'($urandom), 8'($urandom));
      apply(x, 30 + i);
    end
  endtask

`ifdef DISPLAY_OUT_DITHER_EN
  task automatic test_dither();
    in_t st[$];
    int tg[$];
    exp_t e;
    int tile_sum;
    tile_sum = 0;
    for (int i = 0; i < 4; i++) if (fcm + 2'(i) != 2'd0) begin
      st.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0)); tg.push_back(0);
    end
    st.push_back(mk(1, 1, 1, 0, 0, 0, 8'h08, 8'h08, 8'h08)); tg.push_back(50);
    st.push_back(mk(1, 1, 1, 0, 1, 0, 8'h08, 8'h08, 8'h08)); tg.push_back(51);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        st.push_back(mk(1, 1, 1, 0, x, y, 8'h08, 8'h08, 8'h08)); tg.push_back(52);
      end
    st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0)); tg.push_back(0);
    st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0)); tg.push_back(0);
    foreach (st[i]) begin
      @(negedge clk);
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        n_chk++;
        if (act1() !== e.e1) begin n_fail++; $display("FAIL dither tag %0d u1 got %b want %b", e.tag, act1(), e.e1); end
        n_chk++;
        if (act4() !== e.e4) begin n_fail++; $display("FAIL dither tag %0d u4 got %b want %b", e.tag, act4(), e.e4); end
        if (e.tag == 50 || e.tag == 51) begin
          n_chk++;
          if (if4.o_red !== 4'(e.tag - 50)) begin
            n_fail++; $display("FAIL dither_t tag %0d got %h want %h", e.tag, if4.o_red, 4'(e.tag - 50));
          end
        end
        if (e.tag == 52) tile_sum += int'(if4.o_red);
      end
      apply(st[i], tg[i]);
    end
    n_chk++;
    if (tile_sum !== 8) begin n_fail++; $display("FAIL dither_tile sum got %0d want 8", tile_sum); end
  endtask

  task automatic test_saturation();
    in_t st[$];
    int tg[$];
    exp_t e;
    for (int i = 0; i < 4; i++) if (fcm + 2'(i) != 2'd0) begin
      st.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0)); tg.push_back(0);
    end
    st.push_back(mk(1, 1, 1, 0, 0, 3, 8'hFF, 8'hFE, 8'hF0)); tg.push_back(60);
    st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0)); tg.push_back(0);
    st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0)); tg.push_back(0);
    foreach (st[i]) begin
      @(negedge clk);
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        n_chk++;
        if (act1() !== e.e1) begin n_fail++; $display("FAIL satur tag %0d u1 got %b want %b", e.tag, act1(), e.e1); end
        n_chk++;
        if (act4() !== e.e4) begin n_fail++; $display("FAIL satur tag %0d u4 got %b want %b", e.tag, act4(), e.e4); end
        if (e.tag == 60) begin
          n_chk++;
          if ({if1.o_red, if4.o_red} !== 5'b1_1111) begin
            n_fail++; $display("FAIL satur_max got %b%h want 1f", if1.o_red, if4.o_red);
          end
        end
      end
      apply(st[i], tg[i]);
    end
  endtask

  task automatic test_temporal();
    in_t st[$];
    int tg[$];
    exp_t e;
    logic [3:0] pat [4] = '{4'd0, 4'd1, 4'd1, 4'd1};
    for (int i = 0; i < 4; i++) if (fcm + 2'(i) != 2'd0) begin
      st.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0)); tg.push_back(0);
    end
    for (int f = 0; f < 9; f++) begin
      st.push_back(mk(1, 1, 1, 0, 2, 0, 8'h0D, 8'h0D, 8'h0D)); tg.push_back(100 + f);
      st.push_back(mk(1, 0, 0, 1, -8, -2, 8'h0D, 8'h0D, 8'h0D)); tg.push_back(0);
    end
    st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0)); tg.push_back(0);
    st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0)); tg.push_back(0);
    foreach (st[i]) begin
      @(negedge clk);
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        n_chk++;
        if (act1() !== e.e1) begin n_fail++; $display("FAIL temporal tag %0d u1 got %b want %b", e.tag, act1(), e.e1); end
        n_chk++;
        if (act4() !== e.e4) begin n_fail++; $display("FAIL temporal tag %0d u4 got %b want %b", e.tag, act4(), e.e4); end
        if (e.tag >= 100) begin
          n_chk++;
          if (if4.o_red !== pat[(e.tag - 100) % 4]) begin
            n_fail++; $display("FAIL temporal_phase frame %0d got %h want %h", e.tag - 100, if4.o_red, pat[(e.tag - 100) % 4]);
          end
        end
      end
      apply(st[i], tg[i]);
    end
  endtask
`endif

  task automatic test_reset_mid();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      apply(mk(0, 1, 1, 0, i, 5, 8'hFF, 8'hFF, 8'hFF), 80);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (act1() !== RST1) begin n_fail++; $display("FAIL reset_mid_u1 got %b want %b", act1(), RST1); end
    n_chk++;
    if (act4() !== RST4) begin n_fail++; $display("FAIL reset_mid_u4 got %b want %b", act4(), RST4); end
    sb.delete();
    fcm = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{e1: RST1, e4: RST4, tag: 81});
    apply(mk(1, 1, 1, 0, 1, 1, 8'hC0, 8'h40, 8'hA5), 82);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        n_chk++;
        if (act1() !== e.e1) begin n_fail++; $display("FAIL reset_mid tag %0d u1 got %b want %b", e.tag, act1(), e.e1); end
        n_chk++;
        if (act4() !== e.e4) begin n_fail++; $display("FAIL reset_mid tag %0d u4 got %b want %b", e.tag, act4(), e.e4); end
      end
      apply(mk(1, 1, i < 3, 0, i + 2, 1, 8'h81, 8'h3C, 8'hE7), 83);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    fcm    = 2'd0;
    test_reset();
    test_latency();
    test_blanking();
    test_patterns();
`ifdef DISPLAY_OUT_DITHER_EN
    test_dither();
    test_saturation();
    test_temporal();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
